// File: rtl/dpcd_pkg.sv
// dpcd_pkg: shared types, default constants and the high-time helper for
// the multi-channel programmable clock divider.
package dpcd_pkg;

  localparam int DPCD_DIV_W     = 8;
  localparam int DPCD_DIV_RESET = 1;

  typedef logic [DPCD_DIV_W-1:0] div_t;

  // Number of high cycles in a period of the given ratio: ceil(ratio / 2).
  function automatic int unsigned ceil_half(input int unsigned ratio);
    return (ratio + 1) / 2;
  endfunction

endpackage

// File: rtl/dpcd_chan.sv
// dpcd_chan: one divider channel. Holds the period counter, the active and
// pending divide controls, the registered clock/tick outputs and the
// combinational bypass used when the ratio is 1.
module dpcd_chan
  import dpcd_pkg::*;
#(
  parameter int DIV_W     = DPCD_DIV_W,
  parameter int DIV_RESET = DPCD_DIV_RESET
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             acc_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             pending_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] divPend_q, divPend_d;
  logic             pend_q, pend_d;
  logic             enSeen_q;
  logic             clkOut_q, clkOut_d;
  logic             tick_q, tick_d;
  logic             running, wrap, boundary;

  // Next-state logic: a boundary (wrap, disable, first enabled cycle or a
  // sync pulse) restarts the count and is the only place an update lands.
  always_comb begin
    running   = en_i && enSeen_q;
    wrap      = (cnt_q == div_q);
    boundary  = !running || wrap || sync_i;
    cnt_d     = boundary ? '0 : cnt_q + DIV_W'(1);
    div_d     = div_q;
    divPend_d = divPend_q;
    pend_d    = pend_q;
    clkOut_d  = running && (32'(cnt_q) < ceil_half(32'(div_q) + 32'd1));
    tick_d    = running && wrap;
    if (boundary && pend_q) begin
      div_d  = divPend_q;
      pend_d = 1'b0;
    end
    if (acc_i) begin
      divPend_d = div_i;
      pend_d    = 1'b1;
    end
  end

  // State registers; reset discards any pending update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      div_q     <= DIV_W'(DIV_RESET);
      divPend_q <= '0;
      pend_q    <= 1'b0;
      enSeen_q  <= 1'b0;
      clkOut_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      divPend_q <= divPend_d;
      pend_q    <= pend_d;
      enSeen_q  <= en_i;
      clkOut_q  <= clkOut_d;
      tick_q    <= tick_d;
    end
  end

  // Ratio 1 cannot be produced by a register, so the source clock is passed
  // through (gated by the enable) while the active divide control is zero.
  always_comb begin
    clk_out_o = (div_q == '0) ? (clk_i & en_i) : clkOut_q;
  end

  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/dpcd_multi.sv
// dpcd_multi: NUM_CH independent glitch-free programmable clock dividers
// sharing one source clock and one reconfiguration handshake.
// Optional feature: define DPCD_PHASE_SYNC_EN to add the sync_in realign port.
module dpcd_multi
  import dpcd_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int DIV_W     = DPCD_DIV_W,
  parameter  int DIV_RESET = DPCD_DIV_RESET,
  localparam int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_src,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHW-1:0]    cfg_chan,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] clk_tick
`ifdef DPCD_PHASE_SYNC_EN
  ,
  input  logic              sync_in
`endif
);

  logic              chanFree;
  logic [NUM_CH-1:0] accept;
  logic              syncPulse;

  // Ready only when the addressed channel exists and has no update in flight.
  always_comb begin
    chanFree = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_chan == CHW'(i)) chanFree = !pending[i];
    end
  end

  assign cfg_ready = chanFree;

  // Steer an accepted request to exactly one channel.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      accept[i] = cfg_valid && chanFree && (cfg_chan == CHW'(i));
    end
  end

`ifdef DPCD_PHASE_SYNC_EN
  assign syncPulse = sync_in;
`else
  assign syncPulse = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : genChan
    dpcd_chan #(
      .DIV_W    (DIV_W),
      .DIV_RESET(DIV_RESET)
    ) uChan (
      .clk_i    (clk_src),
      .rst_i    (rst),
      .en_i     (ch_en[g]),
      .sync_i   (syncPulse),
      .acc_i    (accept[g]),
      .div_i    (cfg_div),
      .pending_o(pending[g]),
      .clk_out_o(clk_out[g]),
      .tick_o   (clk_tick[g])
    );
  end

endmodule

// File: tb/tb_dpcd_multi.sv
// tb_dpcd_multi: directed bench for dpcd_multi with a ratio-level reference
// model checked every half cycle, plus hand-computed literal expectations.
// Build with DPCD_PHASE_SYNC_EN defined to include the sync_in scenario.
module tb_dpcd_multi;
  import dpcd_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int DIV_RESET = DPCD_DIV_RESET;
  localparam int CHW       = 2;

  logic              clk_src   = 1'b0;
  logic              rst       = 1'b1;
  logic [NUM_CH-1:0] ch_en     = '0;
  logic              cfg_valid = 1'b0;
  logic [CHW-1:0]    cfg_chan  = '0;
  div_t              cfg_div   = '0;
  logic              cfg_ready;
  logic [NUM_CH-1:0] pending, clk_out, clk_tick;
`ifdef DPCD_PHASE_SYNC_EN
  logic              sync_in   = 1'b0;
`endif

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state, expressed as ratio / position within the period.
  int mRatio[NUM_CH];
  int mPos[NUM_CH];
  int mPendRatio[NUM_CH];
  bit mPend[NUM_CH];
  bit mWasEn[NUM_CH];
  bit mOut[NUM_CH];
  bit mTick[NUM_CH];
  bit mSync, mRun, mAcc, mEnd;

  dpcd_multi #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (DPCD_DIV_W),
    .DIV_RESET(DIV_RESET)
  ) dut (
    .clk_src  (clk_src),
    .rst      (rst),
    .ch_en    (ch_en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .pending  (pending),
    .clk_out  (clk_out),
    .clk_tick (clk_tick)
`ifdef DPCD_PHASE_SYNC_EN
    ,
    .sync_in  (sync_in)
`endif
  );

  // Source clock, period 10.
  always #5 clk_src = ~clk_src;

  // Reference model: each rising edge ends a cycle; outputs describe the
  // position the channel was at, and an exhausted period restarts at zero.
  always @(posedge clk_src) begin
`ifdef DPCD_PHASE_SYNC_EN
    mSync = sync_in;
`else
    mSync = 1'b0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        mRatio[i] = DIV_RESET + 1;
        mPos[i]   = 0;
        mPend[i]  = 1'b0;
        mWasEn[i] = 1'b0;
        mOut[i]   = 1'b0;
        mTick[i]  = 1'b0;
      end else begin
        mRun     = ch_en[i] && mWasEn[i];
        mOut[i]  = mRun && (mPos[i] < (mRatio[i] + 1) / 2);
        mTick[i] = mRun && (mPos[i] == mRatio[i] - 1);
        mAcc     = cfg_valid && (int'(cfg_chan) == i) && !mPend[i];
        mEnd     = !mRun || (mPos[i] == mRatio[i] - 1) || mSync;
        if (mEnd) begin
          if (mPend[i]) begin
            mRatio[i] = mPendRatio[i];
            mPend[i]  = 1'b0;
          end
          mPos[i] = 0;
        end else begin
          mPos[i] = mPos[i] + 1;
        end
        if (mAcc) begin
          mPendRatio[i] = int'(cfg_div) + 1;
          mPend[i]      = 1'b1;
        end
        mWasEn[i] = ch_en[i];
      end
    end
  end

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
  endtask

  // Compare every DUT output against the model.
  task automatic checkOutput();
    logic [NUM_CH-1:0] eOut, eTick, ePend;
    for (int i = 0; i < NUM_CH; i++) begin
      eOut[i]  = (mRatio[i] == 1) ? (clk_src & ch_en[i]) : mOut[i];
      eTick[i] = mTick[i];
      ePend[i] = mPend[i];
    end
    checkVal("model_clk_out", 32'(clk_out), 32'(eOut));
    checkVal("model_clk_tick", 32'(clk_tick), 32'(eTick));
    checkVal("model_pending", 32'(pending), 32'(ePend));
    checkVal("model_cfg_ready", 32'(cfg_ready), 32'(!mPend[cfg_chan]));
  endtask

  // Advance n rising edges, leaving time just after the last edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk_src);
      #1;
    end
  endtask

  // Compare process: once in the high phase and once in the low phase.
  initial begin
    forever begin
      @(posedge clk_src);
      #3;
      checkOutput();
      @(negedge clk_src);
      #1;
      checkOutput();
    end
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios with literal expectations.
  initial begin : stim
    int k, hits, first;
    logic [4:0] patOut, patTick;
    logic [1:0] prev;

    $display("[TB] starting dpcd_multi bench");
    applyStimulus(2);
    checkVal("reset_clk_out", 32'(clk_out), 32'h0);
    checkVal("reset_clk_tick", 32'(clk_tick), 32'h0);
    checkVal("reset_pending", 32'(pending), 32'h0);
    checkVal("reset_cfg_ready", 32'(cfg_ready), 32'h1);

    // Ratio 2 on every channel after reset.
    rst = 1'b0;
    ch_en = '1;
    applyStimulus(1);
    checkVal("start_clk_out", 32'(clk_out), 32'h0);
    applyStimulus(1);
    checkVal("div2_high", 32'(clk_out), 32'hF);
    checkVal("div2_tick_low", 32'(clk_tick), 32'h0);
    applyStimulus(1);
    checkVal("div2_low", 32'(clk_out), 32'h0);
    checkVal("div2_tick", 32'(clk_tick), 32'hF);
    applyStimulus(2);

    // Ratio 5 on ch0, requested at the start of a ratio-2 period.
    cfg_valid = 1'b1;
    cfg_chan  = 2'd0;
    cfg_div   = 8'd4;
    #1;
    checkVal("ready_idle", 32'(cfg_ready), 32'h1);
    applyStimulus(1);
    cfg_valid = 1'b0;
    checkVal("pend_set", 32'(pending), 32'h1);
    applyStimulus(1);
    checkVal("pend_applied", 32'(pending), 32'h0);
    patOut  = '0;
    patTick = '0;
    for (int j = 0; j < 5; j++) begin
      applyStimulus(1);
      patOut  = {patOut[3:0], clk_out[0]};
      patTick = {patTick[3:0], clk_tick[0]};
    end
    checkVal("r5_pattern", 32'(patOut), 32'h1C);
    checkVal("r5_tick", 32'(patTick), 32'h01);

    // ch1: accept coincides with its wrap, then a second request stalls.
    cfg_valid = 1'b1;
    cfg_chan  = 2'd1;
    cfg_div   = 8'd5;
    applyStimulus(1);
    cfg_div = 8'd2;
    #1;
    checkVal("stall_pending", 32'(pending[1]), 32'h1);
    checkVal("stall_ready", 32'(cfg_ready), 32'h0);
    applyStimulus(1);
    checkVal("stall_ready2", 32'(cfg_ready), 32'h0);
    applyStimulus(1);
    checkVal("apply_ready", 32'(cfg_ready), 32'h1);
    checkVal("apply_pend", 32'(pending[1]), 32'h0);
    applyStimulus(1);
    cfg_valid = 1'b0;
    checkVal("second_accept", 32'(pending[1]), 32'h1);

    // ch2 ratio 1: source clock passes through, tick stays high.
    cfg_valid = 1'b1;
    cfg_chan  = 2'd2;
    cfg_div   = 8'd0;
    applyStimulus(1);
    cfg_valid = 1'b0;
    applyStimulus(3);
    checkVal("bypass_high", 32'(clk_out[2]), 32'h1);
    checkVal("bypass_tick", 32'(clk_tick[2]), 32'h1);
    #5;
    checkVal("bypass_low", 32'(clk_out[2]), 32'h0);
    applyStimulus(1);
    checkVal("bypass_tick2", 32'(clk_tick[2]), 32'h1);
    ch_en[2] = 1'b0;
    #1;
    checkVal("bypass_gated", 32'(clk_out[2]), 32'h0);
    applyStimulus(1);
    checkVal("disabled_tick", 32'(clk_tick[2]), 32'h0);
    ch_en[2] = 1'b1;

    // ch3: ratio 8, then reset while an update is pending at count 3.
    cfg_valid = 1'b1;
    cfg_chan  = 2'd3;
    cfg_div   = 8'd7;
    applyStimulus(1);
    cfg_valid = 1'b0;
    k = 0;
    while (pending[3] && k < 20) begin
      applyStimulus(1);
      k++;
    end
    checkVal("ch3_apply_in_time", 32'(pending[3]), 32'h0);
    k = 0;
    while (mPos[3] != 1 && k < 20) begin
      applyStimulus(1);
      k++;
    end
    checkVal("ch3_align_in_time", 32'(k < 20), 32'h1);
    cfg_valid = 1'b1;
    cfg_div   = 8'd2;
    applyStimulus(1);
    cfg_valid = 1'b0;
    applyStimulus(1);
    checkVal("rst_pend_before", 32'(pending[3]), 32'h1);
    rst = 1'b1;
    applyStimulus(1);
    checkVal("rst_pending", 32'(pending), 32'h0);
    checkVal("rst_clk_out", 32'(clk_out), 32'h0);
    checkVal("rst_clk_tick", 32'(clk_tick), 32'h0);
    rst = 1'b0;

`ifdef DPCD_PHASE_SYNC_EN
    // ch0 ratio 4, ch1 ratio 6 started out of phase, then realigned.
    ch_en     = 4'b1101;
    cfg_valid = 1'b1;
    cfg_chan  = 2'd0;
    cfg_div   = 8'd3;
    applyStimulus(1);
    cfg_chan = 2'd1;
    cfg_div  = 8'd5;
    applyStimulus(1);
    cfg_valid = 1'b0;
    applyStimulus(6);
    ch_en[1] = 1'b1;
    applyStimulus(5);
    checkVal("sync_pre_pend", 32'(pending), 32'h0);
    sync_in = 1'b1;
    applyStimulus(1);
    sync_in = 1'b0;
    applyStimulus(1);
    prev  = clk_out[1:0];
    hits  = 0;
    first = 0;
    for (int j = 2; j <= 25; j++) begin
      applyStimulus(1);
      if (clk_out[0] && !prev[0] && clk_out[1] && !prev[1]) begin
        hits++;
        if (first == 0) first = j;
      end
      prev = clk_out[1:0];
    end
    checkVal("sync_coincide_hits", 32'(hits), 32'd2);
    checkVal("sync_first_coincide", 32'(first), 32'd13);
`endif

    applyStimulus(2);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
